wide_bram_core: RTL

//  Bus-mapped dual-port block RAM of arbitrary width and depth on the 16-bit daisy-chained register bus.

---
 rtl/bus_pkg.sv | 12 +
 rtl/dual_port_bram.sv | 32 +++
 rtl/wide_bram_core.sv | 87 ++++++++
 3 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared 16-bit register-bus widths and the bus beat struct
package bus_pkg;
  localparam int BUS_WIDTH = 16;
  localparam int BUS_ADDR_WIDTH = 16;
  typedef struct packed {
    logic [BUS_ADDR_WIDTH-1:0] addr;
    logic [BUS_WIDTH-1:0]      wdata;
    logic [BUS_WIDTH-1:0]      rdata;
    logic                      rw;
    logic                      valid;
  } bus_t;
endpackage

// File: rtl/dual_port_bram.sv
// dual_port_bram: two read-first ports on one clock, registered read data
module dual_port_bram #(
  parameter int WIDTH = 18,
  parameter int DEPTH = 256
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [$clog2(DEPTH)-1:0] a_addr,
  input  logic [WIDTH-1:0]         a_din,
  input  logic                     a_we,
  output logic [WIDTH-1:0]         a_dout,
  input  logic [$clog2(DEPTH)-1:0] b_addr,
  input  logic [WIDTH-1:0]         b_din,
  input  logic                     b_we,
  output logic [WIDTH-1:0]         b_dout
);
  logic [WIDTH-1:0] mem [DEPTH];
  always_ff @(posedge clk) begin
    if (a_we) mem[a_addr] <= a_din;
    if (b_we) mem[b_addr] <= b_din;
  end
  // Array contents stay unreset; only the output registers clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_dout <= '0;
      b_dout <= '0;
    end else begin
      a_dout <= mem[a_addr];
      b_dout <= mem[b_addr];
    end
  end
endmodule

// File: rtl/wide_bram_core.sv
// wide_bram_core: bus-mapped wide BRAM with staged atomic multi-word bus writes
module wide_bram_core
  import bus_pkg::*;
#(
  parameter int WIDTH = 18,
  parameter int DEPTH = 256,
  parameter int BASE_ADDR = 0
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [BUS_ADDR_WIDTH-1:0] addr_i,
  input  logic [BUS_WIDTH-1:0]      wdata_i,
  input  logic [BUS_WIDTH-1:0]      rdata_i,
  input  logic                      rw_i,
  input  logic                      valid_i,
  output logic [BUS_ADDR_WIDTH-1:0] addr_o,
  output logic [BUS_WIDTH-1:0]      wdata_o,
  output logic [BUS_WIDTH-1:0]      rdata_o,
  output logic                      rw_o,
  output logic                      valid_o,
  input  logic [$clog2(DEPTH)-1:0]  user_addr,
  input  logic [WIDTH-1:0]          user_din,
  output logic [WIDTH-1:0]          user_dout,
  input  logic                      user_we
);
  localparam int N_WORDS = (WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
  localparam int WB = $clog2(N_WORDS);
  localparam int WW = WB > 0 ? WB : 1;
  localparam int AW = $clog2(DEPTH);
  localparam int STRIDE = 1 << WB;
  localparam int LIMIT = DEPTH * STRIDE;
  bus_t s1, s2, so;
  logic s2_hit;
  logic [WW-1:0] s2_word, word;
  logic [16:0] diff;
  logic hit, last, commit, bus_we;
  logic [AW-1:0] line;
  logic [WIDTH-1:0] stage, stage_n, commit_data, bus_dout;
  logic [N_WORDS*BUS_WIDTH-1:0] padded;
  logic [BUS_WIDTH-1:0] slice;
  // Decode and staging act on stage 1 so a commit lands one edge after sampling.
  always_comb begin
    diff = {1'b0, s1.addr} - 17'(BASE_ADDR);
    hit = s1.valid && !diff[16] && 32'(diff[15:0]) < LIMIT;
    line = AW'(diff[15:0] >> WB);
    word = WW'(diff[15:0] & 16'(STRIDE - 1));
    last = 32'(word) == N_WORDS - 1;
    commit = hit && s1.rw && last;
    bus_we = commit && !(user_we && user_addr == line);
    for (int b = 0; b < WIDTH; b++) begin
      stage_n[b] = (hit && s1.rw && !last && 32'(word) == b / BUS_WIDTH) ? s1.wdata[b % BUS_WIDTH] : stage[b];
      commit_data[b] = (b / BUS_WIDTH == N_WORDS - 1) ? s1.wdata[b % BUS_WIDTH] : stage[b];
    end
    padded = (N_WORDS*BUS_WIDTH)'(bus_dout);
    slice = BUS_WIDTH'(padded >> (32'(s2_word) * BUS_WIDTH));
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      so <= '0;
      s2_hit <= 1'b0;
      s2_word <= '0;
      stage <= '0;
    end else begin
      s1 <= '{addr_i, wdata_i, rdata_i, rw_i, valid_i};
      s2 <= s1;
      s2_hit <= hit && !s1.rw;
      s2_word <= word;
      stage <= stage_n;
      so <= '{s2.addr, s2.wdata, s2_hit ? slice : s2.rdata, s2.rw, s2.valid};
    end
  end
  assign {addr_o, wdata_o, rdata_o, rw_o, valid_o} = so;
  dual_port_bram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_bram (
    .clk(clk),
    .rst_n(rst_n),
    .a_addr(line),
    .a_din(commit_data),
    .a_we(bus_we),
    .a_dout(bus_dout),
    .b_addr(user_addr),
    .b_din(user_din),
    .b_we(user_we),
    .b_dout(user_dout)
  );
endmodule
